// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the tinyCPU fetch/decode/sequencing controller:
// opcode classes, instruction field positions and FSM state encodings.
package cpu_ctrl_pkg;

  localparam logic [3:0] OPC_ALU_MAX = 4'hB;
  localparam logic [3:0] OPC_LDI     = 4'hC;
  localparam logic [3:0] OPC_JMP     = 4'hD;
  localparam logic [3:0] OPC_JCC     = 4'hE;
  localparam logic [3:0] OPC_HALT    = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  function automatic logic is_alu_opc(input logic [3:0] opc);
    return (opc <= OPC_ALU_MAX);
  endfunction

endpackage

// File: rtl/cpu_ctrl_reg_file.sv
// 4-entry register file: two operand read ports, one debug read port,
// one synchronous write port, cleared by the asynchronous reset.
module cpu_ctrl_reg_file #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_rd_sel,
  input  logic [1:0]        i_rs_sel,
  input  logic [1:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rd_data  = r_mem[i_rd_sel];
  assign o_rs_data  = r_mem[i_rs_sel];
  assign o_dbg_data = r_mem[i_dbg_sel];

endmodule

// File: rtl/cpu_ctrl.sv
// tinyCPU controller: fetches from a combinational ROM, decodes, drives the
// external ALU with registered operands and writes its result back.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [15:0]       rom_out,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_e,
  input  logic [1:0]        alu_cc,
  output logic [1:0]        cc,
  output logic              halted,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_op;
  logic [1:0]        r_cc;

  logic [3:0]        w_opc;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs;
  logic [7:0]        w_imm;
  logic [PC_W-1:0]   w_imm_pc;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_rs_data;

  logic              w_ir_ld;
  logic              w_pc_inc;
  logic              w_pc_jmp;
  logic              w_opnd_ld;
  logic              w_cc_ld;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_rf_we_en;

  assign w_opc    = r_ir[OPC_MSB:OPC_LSB];
  assign w_rd     = r_ir[RD_MSB:RD_LSB];
  assign w_rs     = r_ir[RS_MSB:RS_LSB];
  assign w_imm    = r_ir[IMM_MSB:IMM_LSB];
  assign w_imm_pc = PC_W'(w_imm);

  always_comb begin
    w_state_nxt = r_state;
    w_ir_ld     = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_jmp    = 1'b0;
    w_opnd_ld   = 1'b0;
    w_cc_ld     = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_wdata  = alu_e;
    case (r_state)
      ST_FETCH: begin
        w_ir_ld     = 1'b1;
        w_pc_inc    = 1'b1;
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_alu_opc(w_opc)) begin
          w_opnd_ld   = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_FETCH;
          case (w_opc)
            OPC_LDI: begin
              w_rf_we    = 1'b1;
              w_rf_wdata = DATA_W'(w_imm);
            end
            OPC_JMP: w_pc_jmp = 1'b1;
            // rs acts as a condition mask, so rs=0 can never branch
            OPC_JCC: w_pc_jmp = |(r_cc & w_rs);
            default: w_state_nxt = ST_HALT;
          endcase
        end
      end
      ST_EXEC: begin
        w_rf_we     = 1'b1;
        w_cc_ld     = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else if (en) r_state <= w_state_nxt;
  end

  // en gates every update so a stalled instruction resumes exactly where it stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= PC_RESET;
      r_ir     <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_cc     <= '0;
    end else if (en) begin
      if (w_ir_ld) r_ir <= rom_out;
      if (w_pc_jmp) r_pc <= w_imm_pc;
      else if (w_pc_inc) r_pc <= r_pc + PC_W'(1);
      if (w_opnd_ld) begin
        r_alu_a  <= w_rd_data;
        r_alu_b  <= w_rs_data;
        r_alu_op <= w_opc;
      end
      if (w_cc_ld) r_cc <= alu_cc;
    end
  end

  assign w_rf_we_en = en & w_rf_we;

  cpu_ctrl_reg_file #(.DATA_W(DATA_W)) u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_rf_we_en),
    .i_waddr    (w_rd),
    .i_wdata    (w_rf_wdata),
    .i_rd_sel   (w_rd),
    .i_rs_sel   (w_rs),
    .i_dbg_sel  (dbg_sel),
    .o_rd_data  (w_rd_data),
    .o_rs_data  (w_rs_data),
    .o_dbg_data (dbg_data)
  );

  assign rom_addr = r_pc;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign cc       = r_cc;
  assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: instruction-level reference model feeds a scoreboard
// of expected architectural state, checked at each instruction's completion.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  rom_addr;
  logic [15:0] rom_out;
  logic [7:0]  alu_a, alu_b, alu_e, dbg_data;
  logic [3:0]  alu_op;
  logic [1:0]  alu_cc, cc, dbg_sel;
  logic        halted;

  logic [15:0] rom [256];
  logic [1:0]  mon_sel = 2'd0, main_sel = 2'd0;
  logic        mon_active = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << 1;
      4'h6: return a >> 1;
      4'h7: return b;
      4'h8: return ~a;
      4'h9: return a + 8'd1;
      4'hA: return a - 8'd1;
      4'hB: return 8'(a * b);
      default: return a;
    endcase
  endfunction

  function automatic logic [1:0] cc_ref(input logic [7:0] e);
    return {e[7], (e == 8'd0)};
  endfunction

  assign rom_out = rom[rom_addr];
  assign alu_e   = alu_ref(alu_op, alu_a, alu_b);
  assign alu_cc  = cc_ref(alu_e);
  assign dbg_sel = mon_active ? mon_sel : main_sel;

  cpu_ctrl #(.DATA_W(8), .PC_W(8), .PC_RESET(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_out  (rom_out),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_e    (alu_e),
    .alu_cc   (alu_cc),
    .cc       (cc),
    .halted   (halted),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  typedef struct packed {
    int              cyc;
    logic [7:0]      pc;
    logic [3:0][7:0] r;
    logic [1:0]      cc;
    logic            halted;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [3:0]      op;
  } exp_t;

  exp_t sb[$];

  logic [7:0]      m_pc;
  logic [3:0][7:0] m_r;
  logic [1:0]      m_cc;
  logic            m_halt;
  logic [7:0]      m_a, m_b;
  logic [3:0]      m_op;

  function automatic exp_t snap(input int cyc);
    exp_t e;
    e.cyc = cyc; e.pc = m_pc; e.r = m_r; e.cc = m_cc;
    e.halted = m_halt; e.a = m_a; e.b = m_b; e.op = m_op;
    return e;
  endfunction

  // Executes one instruction; returns its cycle count (ALU 3, others 2).
  task automatic model_step(output int lat);
    logic [15:0] ins;
    logic [3:0]  opc;
    logic [1:0]  rd, rs;
    logic [7:0]  imm, res;
    ins = rom[m_pc];
    opc = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
    m_pc = m_pc + 8'd1;
    lat = 2;
    if (opc <= 4'hB) begin
      m_a = m_r[rd]; m_b = m_r[rs]; m_op = opc;
      res = alu_ref(opc, m_r[rd], m_r[rs]);
      m_r[rd] = res;
      m_cc = cc_ref(res);
      lat = 3;
    end else if (opc == 4'hC) m_r[rd] = imm;
    else if (opc == 4'hD) m_pc = imm;
    else if (opc == 4'hE) begin
      if ((m_cc & rs) != 2'b00) m_pc = imm;
    end else m_halt = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic       running = 1'b0;
  int         ecount = 0;
  logic       have_prev = 1'b0;
  logic [7:0] prev_pc;
  logic [1:0] prev_cc;

  initial begin
    logic en_s;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!running) continue;
      en_s = en;
      if (en_s) ecount++;
      @(negedge clk);
      if (!running) continue;
      if (!en_s && have_prev) begin
        chk("stall_pc", rom_addr, prev_pc);
        chk("stall_cc", cc, prev_cc);
      end
      prev_pc = rom_addr; prev_cc = cc; have_prev = 1'b1;
      if (sb.size() != 0 && sb[0].cyc == ecount) begin
        e = sb.pop_front();
        chk("pc", rom_addr, e.pc);
        chk("cc", cc, e.cc);
        chk("halted", halted, e.halted);
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("alu_op", alu_op, e.op);
        mon_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
          mon_sel = 2'(i);
          #1;
          chk($sformatf("R%0d", i), dbg_data, e.r[i]);
        end
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rom_fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic run_phase(input int n_instr);
    int t, lat, budget;
    m_pc = 8'h00; m_r = '0; m_cc = 2'b00; m_halt = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 4'h0;
    t = 0;
    for (int i = 0; i < n_instr; i++) begin
      if (m_halt) break;
      model_step(lat);
      t += lat;
      sb.push_back(snap(t));
    end
    if (m_halt) begin
      sb.push_back(snap(t + 5));
      sb.push_back(snap(t + 20));
    end
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc", rom_addr, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_op", alu_op, 4'h0);
    chk("rst_cc", cc, 2'b00);
    chk("rst_halted", halted, 1'b0);
    for (int i = 0; i < 4; i++) begin
      main_sel = 2'(i);
      #1;
      chk($sformatf("rst_R%0d", i), dbg_data, 8'h00);
    end
    @(negedge clk);
    ecount = 0;
    have_prev = 1'b0;
    rst_n = 1'b1;
    running = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 2000) begin
      @(posedge clk);
      #1;
      en = ($urandom_range(0, 3) != 0);
      budget++;
    end
    if (sb.size() != 0) begin
      chk("sb_timeout", sb.size(), 0);
      sb.delete();
    end
    running = 1'b0;
    en = 1'b1;
  endtask

  task automatic rom_random();
    int k;
    for (int i = 0; i < 256; i++) begin
      k = $urandom_range(0, 15);
      rom[i] = 16'($urandom);
      if (k <= 8 || k >= 14) rom[i][15:12] = 4'($urandom_range(0, 11));
      else if (k <= 11) rom[i][15:12] = 4'hC;
      else if (k == 12) rom[i][15:12] = 4'hD;
      else rom[i][15:12] = 4'hE;
    end
  endtask

  initial begin
    // two LDIs then ADD R0,R1
    rom_fill_halt();
    rom[0] = 16'hC001; rom[1] = 16'hC402; rom[2] = 16'h0100;
    run_phase(3);

    // unconditional jump
    rom_fill_halt();
    rom[0] = 16'hD005; rom[5] = 16'hC1AA;
    run_phase(2);

    // JCC taken on cc=01 (zero result)
    rom_fill_halt();
    rom[0] = 16'hC000; rom[1] = 16'h0000; rom[2] = 16'hE10A; rom[10] = 16'hC155;
    run_phase(4);

    // JCC falls through on cc=10 (negative result)
    rom_fill_halt();
    rom[0] = 16'hC080; rom[1] = 16'h0100; rom[2] = 16'hE10A; rom[3] = 16'hC155;
    run_phase(4);

    // pc wrap from 0xFF
    rom_fill_halt();
    rom[0] = 16'hD0FF; rom[8'hFF] = 16'hC3FF;
    run_phase(2);

    // HALT at address 2, then asynchronous reset while halted
    rom_fill_halt();
    rom[0] = 16'hC001; rom[1] = 16'hC402; rom[2] = 16'hF000;
    run_phase(10);
    @(posedge clk);
    chk("halt_hold", halted, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("halt_async_clr", halted, 1'b0);
    chk("halt_async_pc", rom_addr, 8'h00);

    // randomized programs
    for (int p = 0; p < 4; p++) begin
      rom_random();
      run_phase(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
